alu_share_arbiter: RTL and testbench

//  Shares the single EX-stage ALU between two requesters: port 0 = pipeline EX

---
 rtl/alu_share_arbiter_if.sv | 57 +++++
 rtl/alu_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles the requester handshakes, the flush strobe, the external ALU
//   operand/result path and the response strobes of alu_share_arbiter.
//   slave  : the arbiter's view (requests, flush and alu_result in;
//            readies, alu_* and responses out).
//   master : the surrounding logic's view (the reverse directions).
//   Signals:
//     reqN_valid/reqN_ready/reqN_sel/reqN_a/reqN_b  request port N (N=0,1)
//     flush                                          kill in-flight port-0 ops
//     alu_sel/alu_a/alu_b                            operands to external ALU
//     alu_result                                     combinational ALU result
//     rspN_valid/rspN_data                           one-cycle result strobe
interface alu_share_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [3:0]      req0_sel;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;

    logic            req1_valid;
    logic            req1_ready;
    logic [3:0]      req1_sel;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;

    logic            flush;

    logic [3:0]      alu_sel;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;

    logic            rsp0_valid;
    logic [XLEN-1:0] rsp0_data;
    logic            rsp1_valid;
    logic [XLEN-1:0] rsp1_data;

    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b,
        input  req1_valid, req1_sel, req1_a, req1_b,
        input  flush, alu_result,
        output req0_ready, req1_ready,
        output alu_sel, alu_a, alu_b,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );

    modport master (
        output req0_valid, req0_sel, req0_a, req0_b,
        output req1_valid, req1_sel, req1_a, req1_b,
        output flush, alu_result,
        input  req0_ready, req1_ready,
        input  alu_sel, alu_a, alu_b,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational EX-stage ALU between port 0 (pipeline EX issue)
//   and port 1 (auxiliary CSR/address helper). Port 0 has fixed priority.
//   An accepted op is registered into the issue stage (drives alu_*), the ALU
//   result is registered into the result stage (drives rspN_*): accept in
//   cycle N gives a one-cycle response in N+2, one grant per cycle.
//   Optional feature macro: ALU_ARB_STARVE_GUARD_EN
//     defined     : port 1 denied STARVE_LIMIT consecutive cycles gets one
//                   forced grant (FORCE1 state, port 0 held off that cycle).
//     not defined : pure fixed priority, no counter/FSM.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_share_arbiter_if.slave (requests, flush, ALU path, responses)
module alu_share_arbiter #(
    parameter int unsigned XLEN = 32
`ifdef ALU_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);

    logic grant0;
    logic grant1;
    logic acc0;
    logic acc1;

`ifdef ALU_ARB_STARVE_GUARD_EN
    typedef enum logic {
        PRIO0,
        FORCE1
    } arb_state_e;

    arb_state_e       state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = starve_cnt + CNT_W'(1);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == FORCE1) begin
            grant1 = bus.req1_valid;
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid && !bus.req0_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PRIO0;
            starve_cnt <= '0;
        end else begin
            case (state)
                PRIO0: begin
                    if (bus.req1_valid && !grant1) begin
                        starve_cnt <= cnt_inc;
                        if (cnt_inc == CNT_W'(STARVE_LIMIT)) begin
                            state <= FORCE1;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                FORCE1: begin
                    // One cycle only: either the forced grant happened or
                    // port 1 withdrew; both return to normal priority.
                    state      <= PRIO0;
                    starve_cnt <= '0;
                end
                default: begin
                    state      <= PRIO0;
                    starve_cnt <= '0;
                end
            endcase
        end
    end
`else
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid && !bus.req0_valid;
    end
`endif

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign acc0 = bus.req0_valid && grant0;
    assign acc1 = bus.req1_valid && grant1;

    // Issue stage (owner: 0 = port 0, 1 = port 1)
    logic            iss_valid;
    logic            iss_owner;
    logic [3:0]      iss_sel;
    logic [XLEN-1:0] iss_a;
    logic [XLEN-1:0] iss_b;

    // Result stage
    logic            res_valid;
    logic            res_owner;
    logic [XLEN-1:0] res_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_owner <= 1'b0;
            iss_sel   <= '0;
            iss_a     <= '0;
            iss_b     <= '0;
            res_valid <= 1'b0;
            res_owner <= 1'b0;
            res_data  <= '0;
        end else begin
            // A port-0 accept coinciding with flush is handshaken but dropped.
            iss_valid <= acc1 || (acc0 && !bus.flush);
            iss_owner <= acc1;
            if (acc0 || acc1) begin
                iss_sel <= acc1 ? bus.req1_sel : bus.req0_sel;
                iss_a   <= acc1 ? bus.req1_a   : bus.req0_a;
                iss_b   <= acc1 ? bus.req1_b   : bus.req0_b;
            end
            res_valid <= iss_valid && !(bus.flush && !iss_owner);
            res_owner <= iss_owner;
            if (iss_valid) begin
                res_data <= bus.alu_result;
            end
        end
    end

    assign bus.alu_sel = iss_sel;
    assign bus.alu_a   = iss_a;
    assign bus.alu_b   = iss_b;

    // The result-stage entry is already on the outputs in the flush cycle,
    // so the port-0 strobe is masked combinationally to kill it there.
    assign bus.rsp0_valid = res_valid && !res_owner && !bus.flush;
    assign bus.rsp1_valid = res_valid && res_owner;
    assign bus.rsp0_data  = res_data;
    assign bus.rsp1_data  = res_data;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    localparam int unsigned XLEN = 32;
`ifdef ALU_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
    localparam int LIMIT = 4;
`else
    localparam bit GUARD = 1'b0;
    localparam int LIMIT = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.XLEN(XLEN)) bus ();

    alu_share_arbiter #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return {31'b0, $signed(a) < $signed(b)};
            4'd9:    return {31'b0, a < b};
            default: return 32'h0;
        endcase
    endfunction

    // External combinational ALU
    always_comb bus.alu_result = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);

    typedef struct {
        int unsigned due;
        bit          port;
        logic [31:0] data;
    } rsp_t;

    rsp_t        pend[$];
    int unsigned cyc;
    int          starve;
    bit          forced;
    logic [3:0]  e_sel;
    logic [31:0] e_a, e_b;
    int          checks, failures;
    logic [31:0] got0[$];
    int          n_rsp1;
    bit          r1_hist[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        starve = 0;
        forced = 1'b0;
        e_sel  = '0;
        e_a    = '0;
        e_b    = '0;
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0; bus.req0_sel = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_sel = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.flush = 1'b0;
    endtask

    task automatic set0(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        bus.req0_valid = 1'b1; bus.req0_sel = sel; bus.req0_a = a; bus.req0_b = b;
    endtask

    task automatic set1(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        bus.req1_valid = 1'b1; bus.req1_sel = sel; bus.req1_a = a; bus.req1_b = b;
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_rsp0_valid"}, bus.rsp0_valid, 0);
        chk({tag, "_rsp1_valid"}, bus.rsp1_valid, 0);
        chk({tag, "_rsp0_data"}, bus.rsp0_data, 0);
        chk({tag, "_alu_sel"}, bus.alu_sel, 0);
        chk({tag, "_alu_a"}, bus.alu_a, 0);
        chk({tag, "_alu_b"}, bus.alu_b, 0);
    endtask

    // One clock cycle: inputs already driven; check at negedge, advance model at posedge.
    task automatic tick();
        bit v0, v1, fl, g0, g1, ev0, ev1;
        logic [3:0] s0, s1;
        logic [31:0] a0, b0, a1, b1, ed0, ed1;
        rsp_t keep[$];
        @(negedge clk);
        v0 = bus.req0_valid; v1 = bus.req1_valid; fl = bus.flush;
        s0 = bus.req0_sel; a0 = bus.req0_a; b0 = bus.req0_b;
        s1 = bus.req1_sel; a1 = bus.req1_a; b1 = bus.req1_b;
        if (GUARD && forced) begin
            g0 = 1'b0; g1 = v1;
        end else begin
            g0 = v0; g1 = v1 && !v0;
        end
        chk("req0_ready", bus.req0_ready, g0);
        chk("req1_ready", bus.req1_ready, g1);
        r1_hist.push_back(bus.req1_ready);

        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        foreach (pend[i]) begin
            if (fl && !pend[i].port) continue;   // flush kills every in-flight port-0 op
            if (pend[i].due == cyc) begin
                if (pend[i].port) begin ev1 = 1'b1; ed1 = pend[i].data; end
                else begin ev0 = 1'b1; ed0 = pend[i].data; end
            end else begin
                keep.push_back(pend[i]);
            end
        end
        pend = keep;
        chk("rsp0_valid", bus.rsp0_valid, ev0);
        chk("rsp1_valid", bus.rsp1_valid, ev1);
        if (ev0) chk("rsp0_data", bus.rsp0_data, ed0);
        if (ev1) chk("rsp1_data", bus.rsp1_data, ed1);
        if (bus.rsp0_valid === 1'b1) got0.push_back(bus.rsp0_data);
        if (bus.rsp1_valid === 1'b1) n_rsp1++;
        chk("alu_sel", bus.alu_sel, e_sel);
        chk("alu_a", bus.alu_a, e_a);
        chk("alu_b", bus.alu_b, e_b);

        @(posedge clk);
        if (g1) begin
            e_sel = s1; e_a = a1; e_b = b1;
            pend.push_back('{cyc + 2, 1'b1, alu_f(s1, a1, b1)});
        end else if (g0) begin
            e_sel = s0; e_a = a0; e_b = b0;
            if (!fl) pend.push_back('{cyc + 2, 1'b0, alu_f(s0, a0, b0)});
        end
        if (GUARD) begin
            if (forced) begin
                forced = 1'b0; starve = 0;
            end else if (v1 && !g1) begin
                starve++;
                if (starve == LIMIT) forced = 1'b1;
            end else begin
                starve = 0;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; n_rsp1 = 0;
        model_reset();
        idle();

        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        reset_outputs_zero("reset");
        chk("reset_rsp1_data", bus.rsp1_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op: SUB 10-3
        got0.delete(); n_rsp1 = 0;
        set0(4'd1, 32'd10, 32'd3);
        tick();
        idle();
        repeat (3) tick();
        chk("single_rsp0_count", got0.size(), 1);
        if (got0.size() == 1) chk("single_rsp0_value", got0[0], 7);
        chk("single_rsp1_count", n_rsp1, 0);

        // Contention: both valid for 8 cycles
        r1_hist.delete();
        for (int i = 0; i < 8; i++) begin
            set0(4'd0, $urandom, $urandom);
            set1(4'd4, $urandom, $urandom);
            tick();
        end
        for (int i = 0; i < 8; i++) chk("starve_pattern", r1_hist[i], GUARD && (i == 4));
        idle();
        repeat (3) tick();

        // Back-to-back
        got0.delete();
        set0(4'd0, 32'd1, 32'd1); tick();
        set0(4'd4, 32'd5, 32'd3); tick();
        set0(4'd8, 32'hFFFF_FFFF, 32'd0); tick();
        idle();
        repeat (3) tick();
        chk("b2b_count", got0.size(), 3);
        if (got0.size() == 3) begin
            chk("b2b_0", got0[0], 2);
            chk("b2b_1", got0[1], 6);
            chk("b2b_2", got0[2], 1);
        end

        // Flush
        got0.delete(); n_rsp1 = 0;
        set0(4'd0, 32'd4, 32'd4); tick();
        set0(4'd1, 32'd9, 32'd1); tick();
        idle();
        set1(4'd3, 32'hF0, 32'h0F);
        bus.flush = 1'b1;
        tick();
        idle();
        repeat (3) tick();
        chk("flush_rsp0_count", got0.size(), 0);
        chk("flush_rsp1_count", n_rsp1, 1);

        // Reset with two ops in flight
        set0(4'd2, 32'hFF00, 32'h0FF0); tick();
        idle();
        set1(4'd5, 32'd1, 32'd4); tick();
        idle();
        #2 rst_n = 1'b0;
        #1 reset_outputs_zero("midrst");
        @(posedge clk); #1;
        reset_outputs_zero("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1 reset_outputs_zero("midrst_after");
        @(posedge clk); #1;
        got0.delete();
        set0(4'd9, 32'd3, 32'd8); tick();
        idle();
        repeat (3) tick();
        chk("post_reset_count", got0.size(), 1);
        if (got0.size() == 1) chk("post_reset_value", got0[0], 1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            bus.req0_valid = ($urandom_range(0, 3) != 0);
            bus.req0_sel   = 4'($urandom_range(0, 9));
            bus.req0_a     = $urandom;
            bus.req0_b     = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
            bus.req1_valid = ($urandom_range(0, 1) != 0);
            bus.req1_sel   = 4'($urandom_range(0, 9));
            bus.req1_a     = $urandom;
            bus.req1_b     = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
            bus.flush      = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
